// File: rtl/disparity_framer.sv
// disparity_framer
// Re-imposes raster framing on the free-running disparity stream from the
// stereo core and queues each word in a small FIFO that downstream drains
// through a valid/ready handshake. The pixel pipeline is never stalled. When
// the FIFO is full, a word is dropped, the sticky overflow flag is set, and the
// framer discards words until the next start of frame.
//
// Ports
//   pxclk      in   pixel clock (single clock domain)
//   reset      in   synchronous, active-high reset
//   disparity  in   disparity word from the core
//   dValid     in   disparity qualifier; 0 substitutes INVALID_CODE
//   outData    out  FIFO head data
//   outSof     out  head word is pixel 0 of line 0
//   outEol     out  head word is the last pixel of its line
//   outValid   out  FIFO non-empty
//   outReady   in   downstream accepts the head word this cycle
//   overflow   out  sticky: a word was lost since reset
//   frameCount out  number of start-of-frame words written (wraps)
module disparity_framer #(
  parameter int DISPARITY_DEPTH = 1,
  parameter int PX_CNT_DEPTH    = 3,
  parameter int LINE_CNT_DEPTH  = 3,
  parameter int PIXELS_PER_LINE = 15,
  parameter int LINES_PER_FRAME = 15,
  parameter int INPUT_LATENCY   = 3,
  parameter int FIFO_AW         = 3,
  parameter int INVALID_CODE    = 0,
  parameter int FRAME_CNT_DEPTH = 7
) (
  input  logic                       pxclk,
  input  logic                       reset,
  input  logic [DISPARITY_DEPTH:0]   disparity,
  input  logic                       dValid,
  output logic [DISPARITY_DEPTH:0]   outData,
  output logic                       outSof,
  output logic                       outEol,
  output logic                       outValid,
  input  logic                       outReady,
  output logic                       overflow,
  output logic [FRAME_CNT_DEPTH:0]   frameCount
);

  localparam int DW    = DISPARITY_DEPTH + 1;
  localparam int EW    = DW + 2;               // {sof, eol, data}
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int PW    = PX_CNT_DEPTH + 1;
  localparam int LW    = LINE_CNT_DEPTH + 1;
  localparam int LAT_W = $clog2(INPUT_LATENCY) + 1;

  typedef enum logic [1:0] {WAIT_LAT, RUN, RESYNC} state_t;

  state_t                 state_q;
  logic [LAT_W-1:0]       lat_q;
  logic [PW-1:0]          px_q, px_d;
  logic [LW-1:0]          line_q, line_d;
  logic [FIFO_AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   overflow_q;
  logic [FRAME_CNT_DEPTH:0] frame_cnt_q;
  logic [EW-1:0]          mem_q [DEPTH];

  logic          sof_w, eol_w, full_w, pop_w, push_try_w, push_w;
  logic [DW-1:0] data_w;
  logic [EW-1:0] word_w;

  // Word formed from the current raster position and the incoming sample.
  assign sof_w  = (px_q == '0) && (line_q == '0);
  assign eol_w  = (px_q == PW'(PIXELS_PER_LINE));
  assign data_w = dValid ? disparity : DW'(INVALID_CODE);
  assign word_w = {sof_w, eol_w, data_w};

  assign full_w = (cnt_q == CW'(DEPTH));
  assign pop_w  = (cnt_q != '0) && outReady;
  // RUN writes every pixel; RESYNC only offers the start-of-frame word.
  assign push_try_w = (state_q == RUN) || ((state_q == RESYNC) && sof_w);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_w     = push_try_w && (!full_w || pop_w);

  // Head outputs come straight from storage; outValid tracks the registered count.
  assign {outSof, outEol, outData} = mem_q[rd_ptr_q];
  assign outValid   = (cnt_q != '0);
  assign overflow   = overflow_q;
  assign frameCount = frame_cnt_q;

  always_comb begin
    px_d   = px_q;
    line_d = line_q;
    if (state_q != WAIT_LAT) begin
      if (eol_w) begin
        px_d   = '0;
        line_d = (line_q == LW'(LINES_PER_FRAME)) ? '0 : line_q + 1'b1;
      end else begin
        px_d = px_q + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push_w && !pop_w)      cnt_d = cnt_q + 1'b1;
    else if (!push_w && pop_w) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge pxclk) begin
    if (reset) begin
      state_q     <= WAIT_LAT;
      lat_q       <= '0;
      px_q        <= '0;
      line_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      px_q   <= px_d;
      line_q <= line_d;
      cnt_q  <= cnt_d;
      if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_w && sof_w) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (push_try_w && !push_w) overflow_q <= 1'b1;

      case (state_q)
        WAIT_LAT: begin
          if (lat_q == LAT_W'(INPUT_LATENCY - 1)) state_q <= RUN;
          else                                    lat_q   <= lat_q + 1'b1;
        end
        RUN: begin
          if (!push_w) state_q <= RESYNC;
        end
        RESYNC: begin
          // Only a start-of-frame word that actually lands ends the resync,
          // so downstream never sees a partial frame spliced onto a new one.
          if (sof_w && push_w) state_q <= RUN;
        end
        default: state_q <= WAIT_LAT;
      endcase
    end
  end

  // Storage has no reset: the pointers alone define which entries are live.
  always_ff @(posedge pxclk) begin
    if (push_w) mem_q[wr_ptr_q] <= word_w;
  end

endmodule

// File: tb/tb_disparity_framer.sv
// Directed testbench for disparity_framer.
// u0 uses default parameters; u1 uses a tiny raster (4x2, latency 1).
module tb_disparity_framer;

  logic       pxclk = 1'b0;
  logic       reset, dValid, outReady;
  logic [1:0] disparity;
  logic [1:0] outData;
  logic       outSof, outEol, outValid, overflow;
  logic [7:0] frameCount;

  logic       reset1;
  logic [1:0] outData1;
  logic       outSof1, outEol1, outValid1, overflow1;
  logic [7:0] frameCount1;

  int errors = 0;
  int checks = 0;

  always #5 pxclk = ~pxclk;

  disparity_framer u0 (
    .pxclk(pxclk), .reset(reset), .disparity(disparity), .dValid(dValid),
    .outData(outData), .outSof(outSof), .outEol(outEol), .outValid(outValid),
    .outReady(outReady), .overflow(overflow), .frameCount(frameCount)
  );

  disparity_framer #(
    .INPUT_LATENCY(1), .PIXELS_PER_LINE(3), .LINES_PER_FRAME(1)
  ) u1 (
    .pxclk(pxclk), .reset(reset1), .disparity(2'd1), .dValid(1'b1),
    .outData(outData1), .outSof(outSof1), .outEol(outEol1), .outValid(outValid1),
    .outReady(1'b1), .overflow(overflow1), .frameCount(frameCount1)
  );

  task automatic step();
    @(posedge pxclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic show(input string tag, input int idx);
    $display("%s #%0d: valid=%0b data=%0d sof=%0b eol=%0b ovf=%0b frames=%0d",
             tag, idx, outValid, outData, outSof, outEol, overflow, frameCount);
  endtask

  initial begin
    reset = 1'b1; reset1 = 1'b1; outReady = 1'b1; dValid = 1'b1; disparity = 2'd2;
    step(); step();
    chk("reset_valid", outValid, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_frames", frameCount, 0);

    // Streaming, outReady=1: first word after INPUT_LATENCY+1 cycles.
    reset = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      step();
      chk("latency_no_valid", outValid, 0);
    end
    for (int k = 0; k <= 256; k++) begin
      step();
      show("stream", k);
      chk("stream_valid", outValid, 1);
      chk("stream_data", outData, 2);
      chk("stream_sof", outSof, (k % 256) == 0);
      chk("stream_eol", outEol, (k % 16) == 15);
      chk("stream_overflow", overflow, 0);
      if (k == 255) chk("stream_frames_1", frameCount, 1);
      if (k == 256) chk("stream_frames_2", frameCount, 2);
    end

    // Alternating dValid: invalid samples are still emitted as INVALID_CODE.
    disparity = 2'd3;
    for (int i = 0; i < 8; i++) begin
      dValid = (i % 2) == 0;
      step();
      show("alt", i);
      chk("alt_valid", outValid, 1);
      chk("alt_data", outData, ((i % 2) == 0) ? 3 : 0);
    end

    // outReady=0 from reset: fill 8 words, lose the 9th, resync to next frame.
    reset = 1'b1; outReady = 1'b0; dValid = 1'b1; disparity = 2'd2;
    step();
    chk("ovf_reset_valid", outValid, 0);
    reset = 1'b0;
    for (int s = 1; s <= 11; s++) begin
      step();
      if (s >= 4) chk("fill_valid", outValid, 1);
      chk("fill_overflow", overflow, 0);
    end
    step(); // s=12: ninth write attempt against a full FIFO
    show("full", 12);
    chk("ovf_rises", overflow, 1);
    chk("ovf_valid_held", outValid, 1);
    chk("ovf_head_sof", outSof, 1);
    chk("ovf_frames", frameCount, 1);
    outReady = 1'b1;
    for (int s = 13; s <= 19; s++) begin
      step();
      show("drain", s - 12);
      chk("drain_valid", outValid, 1);
      chk("drain_data", outData, 2);
      chk("drain_sof", outSof, 0);
    end
    for (int s = 20; s <= 259; s++) begin
      step();
      chk("resync_quiet", outValid, 0);
    end
    step(); // s=260: next frame's pixel 0, line 0
    show("resync_sof", 260);
    chk("resync_valid", outValid, 1);
    chk("resync_sof", outSof, 1);
    chk("resync_frames", frameCount, 2);
    chk("resync_ovf_sticky", overflow, 1);
    step();
    chk("resync_run_valid", outValid, 1);
    chk("resync_run_sof", outSof, 0);

    // Full FIFO with pop coinciding with push: no loss, head lags 8 words.
    reset = 1'b1; outReady = 1'b0;
    step();
    reset = 1'b0;
    for (int s = 1; s <= 11; s++) begin
      disparity = 2'(s % 4);
      step();
    end
    chk("full_valid", outValid, 1);
    chk("full_no_ovf", overflow, 0);
    chk("full_head", outData, 0);
    outReady = 1'b1;
    for (int s = 12; s <= 19; s++) begin
      disparity = 2'(s % 4);
      step();
      show("fullpop", s);
      chk("fullpop_no_ovf", overflow, 0);
      chk("fullpop_head", outData, (s - 7) % 4);
    end
    outReady = 1'b0;
    step();
    chk("stall_ovf", overflow, 1);
    outReady = 1'b1;
    step(); step(); step();
    outReady = 1'b0;
    chk("five_left_valid", outValid, 1);

    // One-cycle reset mid-frame with 5 words buffered.
    reset = 1'b1;
    step();
    chk("midreset_valid", outValid, 0);
    chk("midreset_overflow", overflow, 0);
    chk("midreset_frames", frameCount, 0);
    reset = 1'b0; outReady = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      step();
      chk("restart_no_valid", outValid, 0);
    end
    step();
    show("restart", 0);
    chk("restart_valid", outValid, 1);
    chk("restart_sof", outSof, 1);

    // Small raster on u1: 4 pixels x 2 lines, latency 1.
    step();
    reset1 = 1'b0;
    step();
    chk("small_latency", outValid1, 0);
    for (int k = 0; k <= 9; k++) begin
      step();
      $display("small #%0d: valid=%0b data=%0d sof=%0b eol=%0b frames=%0d",
               k, outValid1, outData1, outSof1, outEol1, frameCount1);
      chk("small_valid", outValid1, 1);
      chk("small_sof", outSof1, (k % 8) == 0);
      chk("small_eol", outEol1, (k % 4) == 3);
      if (k == 7) chk("small_frames_1", frameCount1, 1);
      if (k == 8) chk("small_frames_2", frameCount1, 2);
    end
    chk("small_overflow", overflow1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disparity_framer.md
Name: disparity_framer

Overview:
- Output-side companion to the stereo disparity core. It consumes the free-running per-pixel disparity/valid stream and re-imposes raster framing: start-of-frame and end-of-line markers.
- Zero-fills pixels flagged invalid.
- Buffers words in a small FIFO behind a valid/ready handshake, so a stalling downstream consumer (display, DMA, UART bridge) never back-pressures the pixel pipeline.

Parameters:
- DISPARITY_DEPTH, 1, disparity width minus 1
- PX_CNT_DEPTH, 3, pixel counter width minus 1
- LINE_CNT_DEPTH, 3, line counter width minus 1
- PIXELS_PER_LINE, 15, pixels per line minus 1
- LINES_PER_FRAME, 15, lines per frame minus 1
- INPUT_LATENCY, 3, pxclk cycles from reset release to the first disparity word (pixel 0, line 0); must be >= 1
- FIFO_AW, 3, FIFO address bits; depth = 2^FIFO_AW
- INVALID_CODE, 0, value substituted when dValid=0
- FRAME_CNT_DEPTH, 7, frame counter width minus 1

Ports:
- pxclk  in  1  pixel clock; single clock domain
- reset  in  1  synchronous, active-high
- disparity  in  DISPARITY_DEPTH+1  disparity from core
- dValid  in  1  disparity qualifier from core
- outData  out  DISPARITY_DEPTH+1  FIFO head data
- outSof  out  1  head word is pixel 0 of line 0
- outEol  out  1  head word is pixel PIXELS_PER_LINE
- outValid  out  1  FIFO non-empty
- outReady  in  1  downstream accepts head word
- overflow  out  1  sticky, a word was lost
- frameCount  out  FRAME_CNT_DEPTH+1  count of frames started in FIFO

Behaviour:
- Reset (sampled on pxclk rising edge):
  - FIFO pointers and count go to 0; outValid=0 on the following cycle.
  - Pixel/line counters, latency counter, overflow and frameCount go to 0.
  - State goes to WAIT_LAT. Reset mid-frame discards all buffered words.
- WAIT_LAT:
  - Latency counter increments each cycle; no FIFO writes.
  - When it reaches INPUT_LATENCY-1, go to RUN. The first RUN cycle samples pixel 0, line 0.
- Position counters: in RUN and RESYNC, one pixel per cycle, unconditionally.
  - pixel wraps PIXELS_PER_LINE -> 0 and increments line.
  - line wraps LINES_PER_FRAME -> 0.
  - Counters never stall; the input stream has no back-pressure.
- Word formation, each RUN cycle:
  - data = dValid ? disparity : INVALID_CODE
  - sof = (pixel==0 && line==0)
  - eol = (pixel==PIXELS_PER_LINE)
  - Width of the FIFO entry = DISPARITY_DEPTH+3.
- FIFO:
  - Write-to-outValid latency is 1 cycle: a word written at edge t is visible at the head after edge t.
  - Pop occurs when outValid && outReady. Head outputs are driven from storage, not registered again.
  - outData/outSof/outEol are don't-care while outValid=0.
  - Simultaneous push and pop when full: both succeed, count unchanged.
  - Simultaneous push and pop when empty: push only (no read of an empty FIFO).
- Overflow, when a write is attempted while full with no pop in the same cycle:
  - The word is dropped and overflow=1, held until reset.
  - State goes to RESYNC.
- RESYNC:
  - All words are discarded, and the FIFO continues draining.
  - At the first cycle with sof=1, return to RUN; that sof word is written if space exists.
  - Downstream therefore sees a truncated frame followed by a complete frame starting with outSof. No partial line is ever spliced onto the next frame.
  - If the FIFO is still full at that sof, remain in RESYNC until the next sof.
- frameCount increments by 1, with wrap, on every cycle a sof word is actually written.
- RUN ignores outReady for state purposes; only a full-drop transitions it.

Test Plan:
- Reset release, outReady=1, defaults, dValid=1, disparity=2 constant:
  - First outValid occurs 1 cycle after the first RUN cycle, i.e. cycle INPUT_LATENCY+1 after reset release.
  - outSof=1 on the first word; outEol=1 on every 16th word; after 256 words, frameCount=1 and the next word has outSof=1; overflow stays 0.
- Alternating dValid 1/0 with disparity=3:
  - outData sequence 3,0,3,0...; dropped-valid words are still emitted with INVALID_CODE.
- outReady=0 from reset with default depth 8:
  - outValid stays 1 after the 8th write, and overflow rises on the 9th write attempt.
  - Release outReady: exactly 8 words drain, then nothing until line 0 pixel 0 of the next frame. That word has outSof=1 and frameCount=2.
- FIFO held full with outReady toggling every cycle:
  - On cycles where a pop coincides with a push, no overflow occurs; count stays at 8.
- Assert reset for 1 cycle mid-frame with 5 words buffered:
  - The next cycle has outValid=0, overflow=0, frameCount=0.
  - The stream restarts after INPUT_LATENCY cycles with outSof=1.
- INPUT_LATENCY=1, PIXELS_PER_LINE=3, LINES_PER_FRAME=1:
  - Word 0 has outSof; words 3 and 7 have outEol; word 8 has outSof; frameCount=2 after word 8 is written.
